// File: rtl/controle_fila_if.sv
// Button/switch inputs and fila-side strobes of controle_fila.
// master = controller side, slave = fila/board side.
interface controle_fila_if;
  logic       btn_enq_in, btn_deq_in;
  logic [7:0] sw_data_in, len_in;
  logic       enqueue_out, dequeue_out;
  logic [7:0] data_out;
  logic       full_out, empty_out;
  logic [7:0] reject_count_out;

  modport master (
    input  btn_enq_in, btn_deq_in, sw_data_in, len_in,
    output enqueue_out, dequeue_out, data_out, full_out, empty_out, reject_count_out
  );
  modport slave (
    output btn_enq_in, btn_deq_in, sw_data_in, len_in,
    input  enqueue_out, dequeue_out, data_out, full_out, empty_out, reject_count_out
  );
endinterface

// File: rtl/controle_fila.sv
// Push-button enqueue/dequeue controller for a downstream fila.
// Optional debounce filter enabled by macro CONTROLE_FILA_DEBOUNCE_EN.
module controle_fila_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 100
) (
  input  logic clock_10KHz,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  logic [1:0] sync;
  logic       filt, filt_q;

  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_err
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clock_10KHz)
    if (reset) sync <= '0;
    else       sync <= {sync[0], raw};

`ifdef CONTROLE_FILA_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;

  // counter only runs while the synchronized sample disagrees with the level
  always_ff @(posedge clock_10KHz)
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync[1] == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt  <= '0;
      filt <= sync[1];
    end else begin
      cnt  <= cnt + CW'(1);
    end
`else
  assign filt = sync[1];
`endif

  always_ff @(posedge clock_10KHz)
    if (reset) filt_q <= 1'b0;
    else       filt_q <= filt;

  assign rise = filt & ~filt_q;
endmodule

module controle_fila #(
  parameter int unsigned FILA_DEPTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 100
) (
  input  logic             clock_10KHz,
  input  logic             reset,
  controle_fila_if.master  fila
);
  typedef enum logic [1:0] {IDLE, ENQ, DEQ, HOLD} state_t;

  state_t     state, nxt;
  logic [1:0] raw, rise;                 // [0] enqueue, [1] dequeue
  logic       enq_pend, deq_pend, enq_pend_n, deq_pend_n;
  logic       enq_req, deq_req, latch, full, empty;
  logic       enq_q, deq_q;
  logic [7:0] data_q, rej_q;
  logic [1:0] drops, rej_inc;
  logic [8:0] rej_sum;

  assign raw = {fila.btn_deq_in, fila.btn_enq_in};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    controle_fila_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clock_10KHz (clock_10KHz),
      .reset       (reset),
      .raw         (raw[i]),
      .rise        (rise[i])
    );
  end

  assign full    = 32'(fila.len_in) >= FILA_DEPTH;
  assign empty   = fila.len_in == 8'd0;
  assign enq_req = rise[0] | enq_pend;
  assign deq_req = rise[1] | deq_pend;
  // a new edge on a button whose pending slot is occupied is lost
  assign drops   = {1'b0, rise[0] & enq_pend} + {1'b0, rise[1] & deq_pend};

  always_comb begin
    nxt        = state;
    enq_pend_n = enq_pend | rise[0];
    deq_pend_n = deq_pend | rise[1];
    latch      = 1'b0;
    rej_inc    = drops;
    case (state)
      IDLE: begin
        enq_pend_n = 1'b0;
        deq_pend_n = 1'b0;
        if (enq_req) begin
          deq_pend_n = deq_req;          // dequeue waits behind enqueue
          if (full) rej_inc = drops + 2'd1;
          else begin
            nxt   = ENQ;
            latch = 1'b1;
          end
        end else if (deq_req) begin
          if (empty) rej_inc = drops + 2'd1;
          else       nxt = DEQ;
        end
      end
      ENQ, DEQ: nxt = HOLD;
      default:  nxt = IDLE;              // HOLD gives len_in a cycle to settle
    endcase
  end

  assign rej_sum = {1'b0, rej_q} + 9'(rej_inc);

  always_ff @(posedge clock_10KHz)
    if (reset) begin
      state    <= IDLE;
      enq_pend <= 1'b0;
      deq_pend <= 1'b0;
      data_q   <= '0;
      enq_q    <= 1'b0;
      deq_q    <= 1'b0;
      rej_q    <= '0;
    end else begin
      state    <= nxt;
      enq_pend <= enq_pend_n;
      deq_pend <= deq_pend_n;
      if (latch) data_q <= fila.sw_data_in;
      enq_q    <= nxt == ENQ;
      deq_q    <= nxt == DEQ;
      rej_q    <= rej_sum[8] ? 8'hFF : rej_sum[7:0];
    end

  assign fila.enqueue_out      = enq_q;
  assign fila.dequeue_out      = deq_q;
  assign fila.data_out         = data_q;
  assign fila.full_out         = full;
  assign fila.empty_out        = empty;
  assign fila.reject_count_out = rej_q;
endmodule

// File: tb/tb_controle_fila.sv
// Scoreboard bench for controle_fila: stimulus pushes expected strobes,
// a negedge monitor pops and checks kind, data and cycle of every strobe.
module tb_controle_fila;
`ifdef CONTROLE_FILA_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;   // press-to-strobe cycles

  typedef struct {
    logic       is_deq;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n0;
  exp_t expq[$];

  controle_fila_if fif ();

  controle_fila #(.FILA_DEPTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clock_10KHz (clk),
    .reset       (reset),
    .fila        (fif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (fif.enqueue_out === 1'b1 && fif.dequeue_out === 1'b1) begin
      total++; bad++;
      $display("FAIL both_strobes: enqueue and dequeue high together at cyc %0d", cyc);
    end else if (fif.enqueue_out === 1'b1 || fif.dequeue_out === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: deq=%0b at cyc %0d, none expected", fif.dequeue_out, cyc);
      end else begin
        e = expq.pop_front();
        if (fif.dequeue_out !== e.is_deq || cyc != e.cyc ||
            (!e.is_deq && fif.data_out !== e.data)) begin
          bad++;
          $display("FAIL strobe: got deq=%0b cyc=%0d data=%h, expected deq=%0b cyc=%0d data=%h",
                   fif.dequeue_out, cyc, fif.data_out, e.is_deq, e.cyc, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic e, input logic d, input int hold);
    fif.btn_enq_in = e;
    fif.btn_deq_in = d;
    tick(hold);
    fif.btn_enq_in = 1'b0;
    fif.btn_deq_in = 1'b0;
  endtask

  initial begin
    fif.btn_enq_in = 1'b0;
    fif.btn_deq_in = 1'b0;
    fif.sw_data_in = 8'h00;
    fif.len_in     = 8'd0;
    tick(3);
    chk("reset_enq", int'(fif.enqueue_out), 0);
    chk("reset_deq", int'(fif.dequeue_out), 0);
    chk("reset_data", int'(fif.data_out), 0);
    chk("reset_rej", int'(fif.reject_count_out), 0);
    reset = 1'b0;
    tick(5);

    // flag boundaries
    fif.len_in = 8'd0;   #1 chk("empty_len0", int'(fif.empty_out), 1);
    chk("full_len0", int'(fif.full_out), 0);
    fif.len_in = 8'd7;   #1 chk("full_len7", int'(fif.full_out), 0);
    chk("empty_len7", int'(fif.empty_out), 0);
    fif.len_in = 8'd200; #1 chk("full_len200", int'(fif.full_out), 1);
    fif.len_in = 8'd0;
    tick(1);

    // single press
    fif.sw_data_in = 8'h2A;
    expq.push_back('{1'b0, 8'h2A, cyc + LAT});
    press(1'b1, 1'b0, DB + 3);
    tick(12 + DB);
    chk("single_rej", int'(fif.reject_count_out), 0);

    // enqueue while full
    fif.len_in = 8'd8;
    #1 chk("full_len8", int'(fif.full_out), 1);
    tick(1);
    press(1'b1, 1'b0, DB + 3);
    tick(12 + DB);
    chk("full_rej", int'(fif.reject_count_out), 1);

    // simultaneous: enqueue first, dequeue after HOLD and IDLE
    fif.len_in = 8'd3;
    fif.sw_data_in = 8'h55;
    expq.push_back('{1'b0, 8'h55, cyc + LAT});
    expq.push_back('{1'b1, 8'h00, cyc + LAT + 3});
    press(1'b1, 1'b1, DB + 3);
    tick(14 + DB);
    chk("simul_rej", int'(fif.reject_count_out), 1);

`ifndef CONTROLE_FILA_DEBOUNCE_EN
    // overrun: enq edges land in DEQ, in IDLE with pending set, and in HOLD
    fif.sw_data_in = 8'h77;
    n0 = cyc;
    expq.push_back('{1'b1, 8'h00, n0 + 3});
    expq.push_back('{1'b0, 8'h77, n0 + 6});
    expq.push_back('{1'b0, 8'h77, n0 + 9});
    fif.btn_deq_in = 1'b1; tick(1);
    fif.btn_enq_in = 1'b1; tick(1);
    fif.btn_enq_in = 1'b0; tick(1);
    fif.btn_enq_in = 1'b1; tick(1);
    fif.btn_enq_in = 1'b0; tick(1);
    fif.btn_enq_in = 1'b1; tick(1);
    fif.btn_enq_in = 1'b0;
    fif.btn_deq_in = 1'b0;
    tick(15);
    chk("overrun_rej", int'(fif.reject_count_out), 2);
`else
    // bounce: 3-cycle glitch ignored, 10-cycle press accepted
    fif.sw_data_in = 8'h99;
    press(1'b1, 1'b0, 3);
    tick(15);
    expq.push_back('{1'b0, 8'h99, cyc + LAT});
    press(1'b1, 1'b0, 10);
    tick(20);
    chk("bounce_rej", int'(fif.reject_count_out), 1);
`endif

    // reset during HOLD with a dequeue pending
    fif.sw_data_in = 8'hA5;
    n0 = cyc;
    expq.push_back('{1'b0, 8'hA5, n0 + LAT});
    press(1'b1, 1'b1, DB + 1);
    tick(n0 + LAT + 1 - cyc);
    reset = 1'b1;
    tick(1);
    chk("rst_enq", int'(fif.enqueue_out), 0);
    chk("rst_deq", int'(fif.dequeue_out), 0);
    chk("rst_data", int'(fif.data_out), 0);
    chk("rst_rej", int'(fif.reject_count_out), 0);
    reset = 1'b0;
    tick(15 + DB);
    chk("post_rst_rej", int'(fif.reject_count_out), 0);

    // button held through reset release counts as a new press
    fif.len_in = 8'd0;
    fif.sw_data_in = 8'h3C;
    reset = 1'b1;
    fif.btn_enq_in = 1'b1;
    tick(2);
    reset = 1'b0;
    expq.push_back('{1'b0, 8'h3C, cyc + LAT});
    tick(DB + 3);
    fif.btn_enq_in = 1'b0;
    tick(15 + DB);

    // reject counter saturates
    fif.len_in = 8'd8;
    for (int i = 0; i < 260; i++) begin
      press(1'b1, 1'b0, DB + 1);
      tick(DB + 2);
    end
    tick(5);
    chk("rej_saturate", int'(fif.reject_count_out), 255);

    tick(5);
    chk("leftover_expected", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
